// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants and types for the VGA timing path.
// Defaults describe 640x480@60 driven from a 100 MHz clock.
package vga_timing_gen_pkg;

  localparam int CW        = 10;
  localparam int CNT_LIMIT = 1 << CW;

  typedef logic [CW-1:0] coord_t;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int span(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_raster_counter.sv
// One raster axis: wrapping counter plus sync/active decode.
// Decodes describe the post-step value so the caller can register them.
module raster_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int MAX        = 799,
  parameter int SYNC_START = 656,
  parameter int SYNC_LEN   = 96,
  parameter int ACTIVE     = 640
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   step,
  output coord_t cnt,
  output logic   sync,
  output logic   active,
  output logic   wrap
);

  localparam int SYNC_END = SYNC_START + SYNC_LEN;

  coord_t cnt_q;
  coord_t nxt;
  logic   at_max;

  assign at_max = cnt_q == coord_t'(MAX);
  assign wrap   = step & at_max;

  always_comb begin
    nxt = cnt_q;
    if (step)
      nxt = at_max ? '0 : cnt_q + coord_t'(1);
  end

  assign cnt    = nxt;
  assign sync   = ({1'b0, nxt} >= 11'(SYNC_START))
                & ({1'b0, nxt} <  11'(SYNC_END));
  assign active = {1'b0, nxt} < 11'(ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= nxt;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel divider, h/v counters, syncs and
// line/frame strobes for the PPU fetch and output stages.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       pix_en,
  output logic       Hsync,
  output logic       Vsync,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic [9:0] next_y,
  output logic       frame_start
);

  localparam int H_TOTAL = span(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_bad_total
    $error("vga_timing_gen: raster total exceeds 10-bit counters");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_nxt;
  logic          tick;
  logic          run_q;
  logic          step;

  coord_t h_cnt;
  coord_t v_cnt;
  logic   h_sync;
  logic   v_sync;
  logic   h_act;
  logic   v_act;
  logic   h_wrap;
  logic   v_wrap;
  logic   ls_nxt;
  logic   fs_nxt;

  always_comb begin
    div_nxt = div_q + DW'(1);
    if (div_q == DW'(CLK_DIV - 1))
      div_nxt = '0;
  end

  // tick marks the edge that raises pix_en; outputs load on the same edge
  assign tick = div_nxt == DW'(CLK_DIV - 1);
  assign step = tick & run_q;

  raster_counter #(
    .MAX        (H_TOTAL - 1),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC),
    .ACTIVE     (H_ACTIVE)
  ) u_h (
    .clk    (clk),
    .rst_n  (reset_n),
    .step   (step),
    .cnt    (h_cnt),
    .sync   (h_sync),
    .active (h_act),
    .wrap   (h_wrap)
  );

  raster_counter #(
    .MAX        (V_TOTAL - 1),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC),
    .ACTIVE     (V_ACTIVE)
  ) u_v (
    .clk    (clk),
    .rst_n  (reset_n),
    .step   (h_wrap),
    .cnt    (v_cnt),
    .sync   (v_sync),
    .active (v_act),
    .wrap   (v_wrap)
  );

  assign ls_nxt = (h_cnt == coord_t'(H_ACTIVE))
                & ((v_cnt < coord_t'(V_ACTIVE - 1))
                 | (v_cnt == coord_t'(V_TOTAL - 1)));

  // first pixel after reset shows (0,0) without stepping
  assign fs_nxt = ~run_q | v_wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q       <= '0;
      run_q       <= 1'b0;
      pix_en      <= 1'b0;
      Hsync       <= ~SYNC_POL;
      Vsync       <= ~SYNC_POL;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      next_y      <= '0;
      frame_start <= 1'b0;
    end else begin
      div_q  <= div_nxt;
      pix_en <= tick;
      if (tick) begin
        run_q       <= 1'b1;
        Hsync       <= h_sync ? SYNC_POL : ~SYNC_POL;
        Vsync       <= v_sync ? SYNC_POL : ~SYNC_POL;
        active      <= h_act & v_act;
        x           <= h_cnt;
        y           <= v_cnt;
        line_start  <= ls_nxt;
        frame_start <= fs_nxt;
        if (ls_nxt)
          next_y <= (v_cnt == coord_t'(V_TOTAL - 1))
                  ? '0 : v_cnt + coord_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster.
// Expected pixels come from a direct raster model of the timing.
module tb_vga_timing_gen;

  localparam int D    = 3;
  localparam int HA   = 8;
  localparam int HFP  = 2;
  localparam int HS   = 3;
  localparam int HBP  = 2;
  localparam int VA   = 6;
  localparam int VFP  = 1;
  localparam int VS   = 2;
  localparam int VBP  = 2;
  localparam int HT   = HA + HFP + HS + HBP;
  localparam int VT   = VA + VFP + VS + VBP;
  localparam int FRM  = HT * VT;
  localparam bit POL  = 1'b0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_en;
  logic       Hsync;
  logic       Vsync;
  logic       active;
  logic [9:0] x;
  logic [9:0] y;
  logic       line_start;
  logic [9:0] next_y;
  logic       frame_start;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic [9:0] ny;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV  (D),
    .H_ACTIVE (HA),
    .H_FP     (HFP),
    .H_SYNC   (HS),
    .H_BP     (HBP),
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VS),
    .V_BP     (VBP),
    .SYNC_POL (POL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pix_en      (pix_en),
    .Hsync       (Hsync),
    .Vsync       (Vsync),
    .active      (active),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .next_y      (next_y),
    .frame_start (frame_start)
  );

  function automatic logic [35:0] rst_vec();
    return {1'b0, ~POL, ~POL, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 10'd0};
  endfunction

  task automatic test_reset();
    logic [35:0] got;
    reset_n = 1'b0;
    #80;
    @(negedge clk);
    got = {pix_en, Hsync, Vsync, active, x, y,
           line_start, frame_start, next_y};
    total++;
    if (got !== rst_vec()) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", got, rst_vec());
    end
  endtask

  task automatic test_frames(input int npix);
    int   k;
    int   pi;
    int   budget;
    int   act_cnt;
    int   ls_cnt;
    int   fs_n;
    int   fs_k[2];
    logic [9:0] ny;
    logic exp_pe;
    exp_t e;
    exp_t g;
    ny = '0;
    for (int p = 0; p < npix; p++) begin
      int h;
      int v;
      h = p % HT;
      v = (p / HT) % VT;
      e.hs  = (h >= HA + HFP && h < HA + HFP + HS) ? POL : ~POL;
      e.vs  = (v >= VA + VFP && v < VA + VFP + VS) ? POL : ~POL;
      e.act = (h < HA) && (v < VA);
      e.x   = 10'(h);
      e.y   = 10'(v);
      e.ls  = (h == HA) && ((v < VA - 1) || (v == VT - 1));
      e.fs  = (h == 0) && (v == 0);
      if (e.ls)
        ny = (v == VT - 1) ? 10'd0 : 10'(v + 1);
      e.ny  = ny;
      q.push_back(e);
    end
    @(negedge clk);
    reset_n = 1'b1;
    k = 0; pi = 0; act_cnt = 0; ls_cnt = 0; fs_n = 0;
    fs_k[0] = -1; fs_k[1] = -1;
    budget = npix * D + 20;
    for (int c = 0; c < budget && q.size() > 0; c++) begin
      @(negedge clk);
      k++;
      exp_pe = (k % D) == (D - 1);
      total++;
      if (pix_en !== exp_pe) begin
        bad++;
        $display("FAIL pix_en k=%0d got=%b want=%b", k, pix_en, exp_pe);
      end
      if (pix_en === 1'b1) begin
        e = q.pop_front();
        g = '{Hsync, Vsync, active, x, y, line_start, frame_start, next_y};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL pixel p=%0d got=%h want=%h", pi, g, e);
        end
        if (pi < FRM) begin
          act_cnt += int'(active);
          ls_cnt  += int'(line_start);
        end
        if (frame_start === 1'b1 && fs_n < 2) begin
          fs_k[fs_n] = k;
          fs_n++;
        end
        pi++;
      end
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL frames_timeout got=%0d left want=0", q.size());
      q.delete();
    end
    total++;
    if (act_cnt != HA * VA) begin
      bad++;
      $display("FAIL active_count got=%0d want=%0d", act_cnt, HA * VA);
    end
    total++;
    if (ls_cnt != VA) begin
      bad++;
      $display("FAIL line_start_count got=%0d want=%0d", ls_cnt, VA);
    end
    total++;
    if (fs_k[0] != D - 1) begin
      bad++;
      $display("FAIL first_frame_start got=%0d want=%0d", fs_k[0], D - 1);
    end
    total++;
    if (fs_k[1] - fs_k[0] != FRM * D) begin
      bad++;
      $display("FAIL frame_period got=%0d want=%0d",
               fs_k[1] - fs_k[0], FRM * D);
    end
  endtask

  task automatic test_mid_reset(input int x0, input int y0);
    logic [35:0] got;
    bit          hit;
    int          k;
    hit = 1'b0;
    for (int c = 0; c < 2 * FRM * D && !hit; c++) begin
      @(negedge clk);
      if (x === 10'(x0) && y === 10'(y0))
        hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL mid_reset_reach got=none want=x%0d_y%0d", x0, y0);
    end
    reset_n = 1'b0;
    #1;
    got = {pix_en, Hsync, Vsync, active, x, y,
           line_start, frame_start, next_y};
    total++;
    if (got !== rst_vec()) begin
      bad++;
      $display("FAIL mid_reset_async got=%h want=%h", got, rst_vec());
    end
    repeat (3) @(negedge clk);
    got = {pix_en, Hsync, Vsync, active, x, y,
           line_start, frame_start, next_y};
    total++;
    if (got !== rst_vec()) begin
      bad++;
      $display("FAIL mid_reset_hold got=%h want=%h", got, rst_vec());
    end
    reset_n = 1'b1;
    k = 0;
    hit = 1'b0;
    for (int c = 0; c < 4 * D && !hit; c++) begin
      @(negedge clk);
      k++;
      if (pix_en === 1'b1)
        hit = 1'b1;
    end
    total++;
    if (!hit || k != D - 1) begin
      bad++;
      $display("FAIL mid_reset_first_pix got=%0d want=%0d", k, D - 1);
    end
    total++;
    if ({x, y, frame_start, active} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL mid_reset_restart got=x%0d_y%0d_fs%b_act%b want=x0_y0_fs1_act1",
               x, y, frame_start, active);
    end
  endtask

  initial begin
    test_reset();
    test_frames(2 * FRM + 5);
    test_mid_reset(5, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
